lvds_video_tx: RTL and testbench

LVDS_VIDEO_TX -- requirements
Module: lvds_video_tx

---
 rtl/lvds_video_pkg.sv | 55 +++++
 rtl/lvds_lane_shifter.sv | 37 +++
 rtl/lvds_video_tx.sv | 133 +++++++++++++
 tb/tb_lvds_video_tx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_video_pkg.sv
// -----------------------------------------------------------------------------
// lvds_video_pkg
// Shared constants, types and the lane-word builder for the LVDS video
// transmitter.
//   SLOT_COUNT / SLOT_LOAD : 7 bit slots per pixel, the last one is the load slot
//   CLK_PATTERN            : serial pixel-clock word sent on the clock lane
//   mapping_e              : 4-lane bit map selection (VESA / JEIDA)
//   build_lane_word()      : serial word for one data lane, MSB sent first
// -----------------------------------------------------------------------------
package lvds_video_pkg;

    localparam int         SLOT_COUNT  = 7;
    localparam logic [2:0] SLOT_LOAD   = 3'(SLOT_COUNT - 1);
    localparam logic [6:0] CLK_PATTERN = 7'b1100011;

    typedef logic [6:0] lane_word_t;

    typedef enum logic {
        MAP_VESA  = 1'b0,
        MAP_JEIDA = 1'b1
    } mapping_e;

    // Colours are passed zero-extended to 8 bits. With JEIDA the six bits
    // carried on lanes 0..2 are the upper six (index + 2) and the two LSBs
    // move to lane 3; with VESA lanes 0..2 carry bits 0..5 and lane 3 the
    // two MSBs.
    function automatic lane_word_t build_lane_word(
        input logic [1:0] lane,
        input mapping_e   mapping,
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b,
        input logic       hs,
        input logic       vs,
        input logic       de
    );
        logic [5:0] rs;
        logic [5:0] gs;
        logic [5:0] bs;
        lane_word_t word;
        rs = (mapping == MAP_JEIDA) ? r[7:2] : r[5:0];
        gs = (mapping == MAP_JEIDA) ? g[7:2] : g[5:0];
        bs = (mapping == MAP_JEIDA) ? b[7:2] : b[5:0];
        unique case (lane)
            2'd0:    word = {rs[0], rs[1], rs[2], rs[3], rs[4], rs[5], gs[0]};
            2'd1:    word = {gs[1], gs[2], gs[3], gs[4], gs[5], bs[0], bs[1]};
            2'd2:    word = {bs[2], bs[3], bs[4], bs[5], hs, vs, de};
            default: word = (mapping == MAP_JEIDA)
                          ? {r[0], r[1], g[0], g[1], b[0], b[1], 1'b0}
                          : {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/lvds_lane_shifter.sv
// -----------------------------------------------------------------------------
// lvds_lane_shifter
// 7-bit parallel-load, shift-left serialiser for one LVDS lane.
//   clk     : bit clock
//   rst     : asynchronous active-high reset, clears the register
//   load    : load 'word' this cycle, otherwise shift left with zero fill
//   word    : parallel word, bit 6 is sent first
//   ser_out : serial output, taken straight from the register MSB
// -----------------------------------------------------------------------------
module lvds_lane_shifter
    import lvds_video_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  lane_word_t word,
    output logic       ser_out
);

    lane_word_t shreg;

    // NOTE: flops are written with <= so every register in the design samples
    // pre-edge values; blocking assignments here would create order-dependent
    // simulation and mismatch the synthesised netlist.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= word;
        end else begin
            shreg <= {shreg[5:0], 1'b0};
        end
    end

    assign ser_out = shreg[6];

endmodule

// File: rtl/lvds_video_tx.sv
// -----------------------------------------------------------------------------
// lvds_video_tx
// 7:1 LVDS video serialiser: one pixel per 7 bit-clocks over 3 (18-bit colour)
// or 4 (24-bit colour) data lanes plus a serial pixel-clock lane.
//   clk, rst              : bit clock (7x pixel rate), async active-high reset
//   enable                : transmitter enable, acted on at word boundaries
//   pix_valid / pix_ready : pixel handshake, ready pulses in load cycles only
//   hsync, vsync, de      : sync and data-enable qualifiers
//   red, green, blue      : BPC-bit colour components
//   lane_out, clk_lane    : serial data lanes and serial pixel clock
//   active                : high while enabled words are on the lanes
//   underflow_cnt         : saturating count of starved load slots
// -----------------------------------------------------------------------------
module lvds_video_tx
    import lvds_video_pkg::*;
#(
    parameter  int LANES   = 3,
    parameter  int MAPPING = 0,
    parameter  int UFW     = 16,
    localparam int BPC     = (LANES == 4) ? 8 : 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic [BPC-1:0]   red,
    input  logic [BPC-1:0]   green,
    input  logic [BPC-1:0]   blue,
    output logic [LANES-1:0] lane_out,
    output logic             clk_lane,
    output logic             active,
    output logic [UFW-1:0]   underflow_cnt
);

    if (LANES != 3 && LANES != 4) begin : g_bad_lanes
        $error("lvds_video_tx: LANES must be 3 or 4");
    end

    // MAPPING only matters when a fourth lane exists.
    localparam mapping_e MAP_SEL = (LANES == 4 && MAPPING == 1) ? MAP_JEIDA : MAP_VESA;

    logic [2:0] slot;
    logic       load;
    logic       transfer;
    logic       hs_held;
    logic       vs_held;
    logic       first_seen;
    logic       enable_q;
    lane_word_t clk_word;

    assign load     = (slot == SLOT_LOAD);
    // pix_ready is only ever high in a load cycle, so this is the transfer.
    assign transfer = pix_valid && pix_ready;

    // Slot counter and word-level control. pix_ready is registered from the
    // slot before the load, so enable is effectively sampled once per word and
    // a load cycle with pix_ready low is an idle (disabled) word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot          <= SLOT_LOAD;
            pix_ready     <= 1'b0;
            active        <= 1'b0;
            hs_held       <= 1'b0;
            vs_held       <= 1'b0;
            first_seen    <= 1'b0;
            enable_q      <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            slot      <= load ? 3'd0 : slot + 3'd1;
            pix_ready <= (slot == SLOT_LOAD - 3'd1) && enable;
            enable_q  <= enable;

            if (load) begin
                active <= pix_ready;
            end

            // Starved slots count only once the stream has actually started.
            if (load && pix_ready && !pix_valid && first_seen
                && underflow_cnt != {UFW{1'b1}}) begin
                underflow_cnt <= underflow_cnt + 1'b1;
            end

            if (transfer) begin
                hs_held    <= hsync;
                vs_held    <= vsync;
                first_seen <= 1'b1;
            end else if (enable && !enable_q) begin
                first_seen <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_word_t word;

        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        always_comb begin
            word = '0;
            if (transfer) begin
                word = build_lane_word(2'(i), MAP_SEL, 8'(red), 8'(green), 8'(blue),
                                       hsync, vsync, de);
            end else if (pix_ready) begin
                // Blanking: no colour, de low, sync levels frozen at last pixel.
                word = build_lane_word(2'(i), MAP_SEL, 8'h00, 8'h00, 8'h00,
                                       hs_held, vs_held, 1'b0);
            end
        end

        lvds_lane_shifter u_shifter (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .word    (word),
            .ser_out (lane_out[i])
        );
    end

    assign clk_word = pix_ready ? CLK_PATTERN : '0;

    lvds_lane_shifter u_clk_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .word    (clk_word),
        .ser_out (clk_lane)
    );

endmodule

// File: tb/tb_lvds_video_tx.sv
// -----------------------------------------------------------------------------
// tb_lvds_video_tx
// Drives a 3-lane VESA instance (UFW=16) and a 4-lane JEIDA instance (UFW=2)
// with the same control stimulus and checks both against a word-level model:
// each accepted/blank/idle word is expanded from a table of source bits into
// expected serial bit queues.
// -----------------------------------------------------------------------------
module tb_lvds_video_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       pix_valid;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [7:0] red8;
    logic [7:0] green8;
    logic [7:0] blue8;

    logic        rdy3, clk3, act3;
    logic [2:0]  lane3;
    logic [15:0] uf3;
    logic        rdy4, clk4, act4;
    logic [3:0]  lane4;
    logic [1:0]  uf4;

    logic [6:0] o3_now;
    logic [6:0] o4_now;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lvds_video_tx #(.LANES(3), .MAPPING(0), .UFW(16)) dut3 (
        .clk (clk), .rst (rst), .enable (enable),
        .pix_valid (pix_valid), .pix_ready (rdy3),
        .hsync (hsync), .vsync (vsync), .de (de),
        .red (red8[5:0]), .green (green8[5:0]), .blue (blue8[5:0]),
        .lane_out (lane3), .clk_lane (clk3), .active (act3),
        .underflow_cnt (uf3)
    );

    lvds_video_tx #(.LANES(4), .MAPPING(1), .UFW(2)) dut4 (
        .clk (clk), .rst (rst), .enable (enable),
        .pix_valid (pix_valid), .pix_ready (rdy4),
        .hsync (hsync), .vsync (vsync), .de (de),
        .red (red8), .green (green8), .blue (blue8),
        .lane_out (lane4), .clk_lane (clk4), .active (act4),
        .underflow_cnt (uf4)
    );

    // Observed bundles: {act, clk_lane, pix_ready, lanes}; bit 6 of o3 is pad.
    assign o3_now = {1'b0, act3, clk3, rdy3, lane3};
    assign o4_now = {act4, clk4, rdy4, lane4};

    // ---------------- reference model ----------------
    // Source bit codes: R i = i, G i = 8+i, B i = 16+i, HS 24, VS 25, DE 26, zero 27.
    int   map_tab [2][4][7];
    bit   q [2][6][$];        // per instance: lanes 0..3, clock lane 4, active 5
    int   m_slot;
    bit   m_ready, m_first, m_hs, m_vs, m_en_prev;
    int   u3, u4;
    logic [6:0] e3, e4;

    task automatic init_tables();
        map_tab[0][0] = '{0, 1, 2, 3, 4, 5, 8};
        map_tab[0][1] = '{9, 10, 11, 12, 13, 16, 17};
        map_tab[0][2] = '{18, 19, 20, 21, 24, 25, 26};
        map_tab[0][3] = '{6, 7, 14, 15, 22, 23, 27};
        map_tab[1][0] = '{2, 3, 4, 5, 6, 7, 10};
        map_tab[1][1] = '{11, 12, 13, 14, 15, 18, 19};
        map_tab[1][2] = '{20, 21, 22, 23, 24, 25, 26};
        map_tab[1][3] = '{0, 1, 8, 9, 16, 17, 27};
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int l = 0; l < 6; l++) q[d][l].delete();
        m_slot = 6; m_ready = 0; m_first = 0; m_hs = 0; m_vs = 0; m_en_prev = 0;
        u3 = 0; u4 = 0; e3 = '0; e4 = '0;
    endtask

    // Called right at a rising edge, with the inputs as the DUT sampled them.
    task automatic model_edge();
        logic [27:0] src;
        bit xfer;
        bit b [2][6];
        if (rst) begin
            model_reset();
            return;
        end
        xfer = (m_slot == 6) && m_ready && pix_valid;
        if (m_slot == 6) begin
            if (xfer) src = {1'b0, de, vsync, hsync, blue8, green8, red8};
            else      src = {2'b00, m_vs, m_hs, 24'h0};
            for (int d = 0; d < 2; d++) begin
                for (int l = 0; l < 4; l++)
                    for (int k = 0; k < 7; k++)
                        q[d][l].push_back(m_ready ? src[map_tab[d][l][k]] : 1'b0);
                for (int k = 0; k < 7; k++) begin
                    q[d][4].push_back(m_ready && (k < 2 || k > 4));
                    q[d][5].push_back(m_ready);
                end
            end
            if (m_ready && !pix_valid && m_first) begin
                if (u3 < 65535) u3++;
                if (u4 < 3) u4++;
            end
        end
        if (xfer) begin
            m_first = 1; m_hs = hsync; m_vs = vsync;
        end else if (enable && !m_en_prev) begin
            m_first = 0;
        end
        m_en_prev = enable;
        m_ready   = (m_slot == 5) && enable;
        m_slot    = (m_slot + 1) % 7;
        for (int d = 0; d < 2; d++)
            for (int l = 0; l < 6; l++)
                b[d][l] = (q[d][l].size() > 0) ? q[d][l].pop_front() : 1'b0;
        e3 = {1'b0, b[0][5], b[0][4], m_ready, b[0][2], b[0][1], b[0][0]};
        e4 = {b[1][5], b[1][4], m_ready, b[1][3], b[1][2], b[1][1], b[1][0]};
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Aligns to the start of a word and records its 7 bit times, observed and expected.
    task automatic run_word(output logic [6:0][6:0] o3, output logic [6:0][6:0] x3,
                            output logic [6:0][6:0] o4, output logic [6:0][6:0] x4);
        int guard = 0;
        do begin
            cycle();
            guard++;
        end while (m_slot != 0 && guard < 8);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) cycle();
            o3[k] = o3_now; x3[k] = e3; o4[k] = o4_now; x4[k] = e4;
        end
    endtask

    function automatic logic [6:0] lane_bits(input logic [6:0][6:0] w, input int idx);
        logic [6:0] r;
        for (int k = 0; k < 7; k++) r[6 - k] = w[k][idx];
        return r;
    endfunction

    task automatic randomize_pixel();
        red8 = 8'($urandom); green8 = 8'($urandom); blue8 = 8'($urandom);
        hsync = 1'($urandom); vsync = 1'($urandom); de = 1'($urandom);
    endtask

    // ---------------- tests ----------------
    logic [6:0][6:0] o3, x3, o4, x4;

    task automatic test_reset();
        rst = 1; enable = 0; pix_valid = 0; hsync = 0; vsync = 0; de = 0;
        red8 = 0; green8 = 0; blue8 = 0;
        repeat (3) cycle();
        checks++;
        if ({o3_now, o4_now, uf3, uf4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h uf %0d/%0d, expected all 0", o3_now, o4_now, uf3, uf4);
        end
        rst = 0; enable = 1;
        run_word(o3, x3, o4, x4);
        checks++;
        if (o3 !== x3 || o4 !== x4) begin
            errors++;
            $display("FAIL first_word_model: got %h/%h expected %h/%h", o3, o4, x3, x4);
        end
        checks++;
        if ((lane_bits(o3, 0) | lane_bits(o3, 1) | lane_bits(o3, 2) | lane_bits(o3, 4)
             | lane_bits(o4, 3) | lane_bits(o4, 5)) !== 7'b0) begin
            errors++;
            $display("FAIL first_word_zero: lanes carried data in first word after reset");
        end
    endtask

    task automatic test_known_patterns();
        pix_valid = 1; red8 = 8'h01; green8 = 0; blue8 = 0; hsync = 0; vsync = 0; de = 0;
        repeat (2) run_word(o3, x3, o4, x4);
        checks++;
        if (lane_bits(o3, 0) !== 7'b1000000 || lane_bits(o3, 4) !== 7'b1100011) begin
            errors++;
            $display("FAIL pattern_r01_3lane: lane0 %b clk %b, expected 1000000 1100011",
                     lane_bits(o3, 0), lane_bits(o3, 4));
        end
        checks++;
        if (lane_bits(o4, 3) !== 7'b1000000 || lane_bits(o4, 5) !== 7'b1100011) begin
            errors++;
            $display("FAIL pattern_r01_jeida: lane3 %b clk %b, expected 1000000 1100011",
                     lane_bits(o4, 3), lane_bits(o4, 5));
        end
        red8 = 8'h03;
        run_word(o3, x3, o4, x4);
        checks++;
        if (lane_bits(o4, 3) !== 7'b1100000
            || (lane_bits(o4, 0) | lane_bits(o4, 1) | lane_bits(o4, 2)) !== 7'b0) begin
            errors++;
            $display("FAIL pattern_r03_jeida: lane3 %b lanes0..2 %b %b %b, expected 1100000 and zeros",
                     lane_bits(o4, 3), lane_bits(o4, 0), lane_bits(o4, 1), lane_bits(o4, 2));
        end
        de = 1;
        run_word(o3, x3, o4, x4);
        checks++;
        if (lane_bits(o4, 2) !== 7'b0000001 || lane_bits(o4, 3) !== 7'b1100000) begin
            errors++;
            $display("FAIL pattern_r03_de_jeida: lane2 %b lane3 %b, expected 0000001 1100000",
                     lane_bits(o4, 2), lane_bits(o4, 3));
        end
        checks++;
        if (o3 !== x3 || o4 !== x4) begin
            errors++;
            $display("FAIL pattern_model: got %h/%h expected %h/%h", o3, o4, x3, x4);
        end
    endtask

    task automatic test_random_stream();
        for (int w = 0; w < 30; w++) begin
            enable    = ($urandom_range(0, 9) != 0);
            pix_valid = ($urandom_range(0, 4) != 0);
            randomize_pixel();
            run_word(o3, x3, o4, x4);
            checks++;
            if (o3 !== x3) begin
                errors++;
                $display("FAIL random_word3[%0d]: got %h expected %h", w, o3, x3);
            end
            checks++;
            if (o4 !== x4) begin
                errors++;
                $display("FAIL random_word4[%0d]: got %h expected %h", w, o4, x4);
            end
            checks++;
            if (uf3 !== 16'(u3) || uf4 !== 2'(u4)) begin
                errors++;
                $display("FAIL random_underflow[%0d]: got %0d/%0d expected %0d/%0d", w, uf3, uf4, u3, u4);
            end
        end
    endtask

    task automatic test_underflow();
        rst = 1;
        cycle();
        rst = 0; enable = 1; pix_valid = 1;
        randomize_pixel();
        hsync = 1; vsync = 0; de = 1;
        repeat (2) run_word(o3, x3, o4, x4);
        pix_valid = 0; hsync = 0; vsync = 1;
        for (int w = 0; w < 5; w++) begin
            run_word(o3, x3, o4, x4);
            checks++;
            if (o3 !== x3 || o4 !== x4) begin
                errors++;
                $display("FAIL starve_model[%0d]: got %h/%h expected %h/%h", w, o3, o4, x3, x4);
            end
            checks++;
            if (lane_bits(o3, 2) !== 7'b0000100 || lane_bits(o3, 0) !== 7'b0) begin
                errors++;
                $display("FAIL blank_word[%0d]: lane2 %b lane0 %b, expected 0000100 0000000",
                         w, lane_bits(o3, 2), lane_bits(o3, 0));
            end
            if (w == 2) begin
                checks++;
                if (uf3 !== 16'd3 || uf4 !== 2'd3) begin
                    errors++;
                    $display("FAIL underflow_3: got %0d/%0d expected 3/3", uf3, uf4);
                end
            end
        end
        checks++;
        if (uf3 !== 16'd5 || uf4 !== 2'd3) begin
            errors++;
            $display("FAIL underflow_saturate: got %0d/%0d expected 5/3", uf3, uf4);
        end
    endtask

    task automatic test_enable_drop();
        int guard;
        int saved;
        enable = 1; pix_valid = 1;
        randomize_pixel();
        run_word(o3, x3, o4, x4);
        repeat (3) cycle();
        enable = 0;
        guard = 0;
        while (m_slot != 6 && guard < 10) begin
            cycle();
            guard++;
            checks++;
            if (o3_now !== e3 || o4_now !== e4) begin
                errors++;
                $display("FAIL drop_tail: got %h/%h expected %h/%h", o3_now, o4_now, e3, e4);
            end
        end
        run_word(o3, x3, o4, x4);
        checks++;
        if (o3 !== '0 || o4 !== '0) begin
            errors++;
            $display("FAIL disabled_word: got %h/%h expected all 0", o3, o4);
        end
        saved = u3;
        enable = 1; pix_valid = 0;
        repeat (3) run_word(o3, x3, o4, x4);
        checks++;
        if (uf3 !== 16'(saved) || o3 !== x3 || o4 !== x4) begin
            errors++;
            $display("FAIL reenable_no_count: uf %0d expected %0d, words %h/%h expected %h/%h",
                     uf3, saved, o3, o4, x3, x4);
        end
        pix_valid = 1;
        run_word(o3, x3, o4, x4);
        pix_valid = 0;
        run_word(o3, x3, o4, x4);
        checks++;
        if (uf3 !== 16'(saved + 1)) begin
            errors++;
            $display("FAIL reenable_count: got %0d expected %0d", uf3, saved + 1);
        end
    endtask

    task automatic test_reset_mid_word();
        int guard = 0;
        int n = 0;
        enable = 1; pix_valid = 1;
        randomize_pixel();
        run_word(o3, x3, o4, x4);
        while (m_slot != 3 && guard < 10) begin
            cycle();
            guard++;
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({o3_now, o4_now, uf3, uf4} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h/%h uf %0d/%0d, expected all 0", o3_now, o4_now, uf3, uf4);
        end
        cycle();
        rst = 0;
        while (n < 20) begin
            cycle();
            n++;
            checks++;
            if (o3_now !== e3 || o4_now !== e4) begin
                errors++;
                $display("FAIL post_reset[%0d]: got %h/%h expected %h/%h", n, o3_now, o4_now, e3, e4);
            end
            if (act3) break;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL restart_latency: first active after %0d cycles, expected 8", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        init_tables();
        model_reset();
        test_reset();
        test_known_patterns();
        test_random_stream();
        test_underflow();
        test_enable_drop();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
